// File: rtl/palette_pkg.sv
// Shared definitions for the palette LUT: colour modes, default gradient,
// and constant colour levels.
package palette_pkg;

    typedef enum logic [1:0] {
        MODE_BW    = 2'd0,
        MODE_CLAMP = 2'd1,
        MODE_WRAP  = 2'd2,
        MODE_GRAY  = 2'd3
    } mode_e;

    // Replicated per bit to form full-width black / white pixels.
    localparam logic CH_BLACK = 1'b0;
    localparam logic CH_WHITE = 1'b1;

    localparam int DEF_PAL_DEPTH = 32;

    // Default 32-entry gradient, {R,G,B} at 8 bits per channel, index 0 first.
    localparam logic [0:DEF_PAL_DEPTH-1][23:0] DEFAULT_PAL = '{
        24'h000000, 24'h01000A, 24'h020014, 24'h04001F,
        24'h05012D, 24'h06023C, 24'h08044B, 24'h0A085A,
        24'h0C0F6A, 24'h0F1A7A, 24'h12288A, 24'h153C9C,
        24'h1852B1, 24'h1C60C0, 24'h2070CC, 24'h2480D6,
        24'h2990DE, 24'h2EA0E4, 24'h34B0E8, 24'h3AC0EA,
        24'h40CCE0, 24'h46D0C8, 24'h4CCCA8, 24'h52C088,
        24'h58B068, 24'h5EA04C, 24'h629034, 24'h667820,
        24'h645E14, 24'h5E460C, 24'h583008, 24'h522205
    };

    // Gradient entry for any palette index; deeper palettes repeat it.
    function automatic logic [23:0] default_entry(input int i);
        return DEFAULT_PAL[5'(i)];
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: one write port, one synchronous read-first
// read port, power-up contents taken from the default gradient.
module palette_ram
    import palette_pkg::*;
#(
    parameter int AW      = 5,
    parameter int COLOR_W = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [3*COLOR_W-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [3*COLOR_W-1:0] o_rdata
);

    localparam int DEPTH = 2**AW;
    localparam int DW    = 3*COLOR_W;

    typedef logic [DW-1:0] mem_t [DEPTH];

    // Each 8-bit gradient channel is left-aligned into COLOR_W bits so the
    // gradient keeps its shape at any channel width (up to 32 bits).
    function automatic mem_t init_mem();
        mem_t        m;
        logic [23:0] e;
        logic [31:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            e = default_entry(i);
            for (int c = 0; c < 3; c++) begin
                t = {e[c*8 +: 8], 24'h000000};
                m[i][c*COLOR_W +: COLOR_W] = t[31 -: COLOR_W];
            end
        end
        return m;
    endfunction

    mem_t          r_mem = init_mem();
    logic [DW-1:0] r_rdata;

    // Write and read on the same edge; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/palette_lut.sv
// Pipelined iteration-count to RGB mapper with a writable palette, four
// colour modes and frame-synchronous palette rotation. Two-cycle latency.
module palette_lut
    import palette_pkg::*;
#(
    parameter int ITER_W   = 7,
    parameter int MAX_ITER = 99,
    parameter int PAL_AW   = 5,
    parameter int COLOR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ITER_W-1:0]    in_iter,
    input  logic [1:0]           mode,
    input  logic                 frame_start,
    input  logic                 cycle_en,
    input  logic [3:0]           cycle_div,
    input  logic                 pal_we,
    input  logic [PAL_AW-1:0]    pal_waddr,
    input  logic [3*COLOR_W-1:0] pal_wdata,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   o_RED,
    output logic [COLOR_W-1:0]   o_GREEN,
    output logic [COLOR_W-1:0]   o_BLUE,
    output logic [PAL_AW-1:0]    rot_offset
);

    localparam int PAL_MAX = 2**PAL_AW - 1;
    localparam int IW      = (ITER_W > PAL_AW) ? ITER_W : PAL_AW;
    localparam int GW      = ITER_W + COLOR_W;
    localparam int DW      = 3*COLOR_W;

    // Rotation state
    logic [3:0]        r_fcnt;
    logic [PAL_AW-1:0] r_rot;

    // Stage-1 state; r_vld_pipe[0] qualifies stage 1, [1] the output
    logic [1:0]         r_vld_pipe;
    mode_e              r_s1_mode;
    logic               r_s1_set;
    logic [COLOR_W-1:0] r_s1_gray;

    // Output stage
    logic [DW-1:0] r_rgb;

    // Stage-1 combinational decode
    mode_e              w_mode;
    logic               w_in_set;
    logic [IW-1:0]      w_iter_ext;
    logic [PAL_AW-1:0]  w_idx;
    logic [GW-1:0]      w_gray_ext;
    logic [COLOR_W-1:0] w_gray;
    logic [DW-1:0]      w_rdata;

    assign w_mode     = mode_e'(mode);
    assign w_in_set   = (32'(in_iter) >= 32'(MAX_ITER));
    assign w_iter_ext = IW'(in_iter);
    // Left-align the count into the channel; wide counts keep their MSBs.
    assign w_gray_ext = {in_iter, {COLOR_W{1'b0}}};
    assign w_gray     = w_gray_ext[GW-1 -: COLOR_W];

    // Palette index: saturating for clamp, rotated and wrapping for wrap.
    // B&W and grayscale ignore the palette, so the clamp index is harmless.
    always_comb begin
        w_idx = (w_iter_ext > IW'(PAL_MAX)) ? PAL_AW'(PAL_MAX)
                                            : w_iter_ext[PAL_AW-1:0];
        if (w_mode == MODE_WRAP)
            w_idx = w_iter_ext[PAL_AW-1:0] + r_rot;
    end

    // The RAM's address register is the stage-1 index register: the index
    // is captured on the stage-1 edge and the data comes back for stage 2.
    palette_ram #(
        .AW      (PAL_AW),
        .COLOR_W (COLOR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (pal_we),
        .i_waddr (pal_waddr),
        .i_wdata (pal_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Frame counter and rotation offset, stepping every cycle_div+1 frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
            r_rot  <= '0;
        end else if (frame_start && cycle_en) begin
            if (r_fcnt == cycle_div) begin
                r_fcnt <= '0;
                r_rot  <= r_rot + 1'b1;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Stage 1: register valid, mode, in-set flag and gray level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1_mode  <= MODE_BW;
            r_s1_set   <= 1'b0;
            r_s1_gray  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
            r_s1_mode  <= w_mode;
            r_s1_set   <= w_in_set;
            r_s1_gray  <= w_gray;
        end
    end

    // Stage 2: registered output mux; invalid and in-set pixels are black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= {DW{CH_BLACK}};
        end else if (!r_vld_pipe[0] || r_s1_set) begin
            r_rgb <= {DW{CH_BLACK}};
        end else begin
            case (r_s1_mode)
                MODE_BW:   r_rgb <= {DW{CH_WHITE}};
                MODE_GRAY: r_rgb <= {r_s1_gray, r_s1_gray, r_s1_gray};
                default:   r_rgb <= w_rdata;
            endcase
        end
    end

    assign out_valid  = r_vld_pipe[1];
    assign o_RED      = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign o_GREEN    = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign o_BLUE     = r_rgb[COLOR_W-1:0];
    assign rot_offset = r_rot;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut with a behavioural reference model.
module tb_palette_lut;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  in_iter = '0;
    logic [1:0]  mode = '0;
    logic        frame_start = 1'b0;
    logic        cycle_en = 1'b0;
    logic [3:0]  cycle_div = '0;
    logic        pal_we = 1'b0;
    logic [4:0]  pal_waddr = '0;
    logic [23:0] pal_wdata = '0;
    logic        out_valid;
    logic [7:0]  o_RED, o_GREEN, o_BLUE;
    logic [4:0]  rot_offset;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    palette_lut #(.ITER_W(7), .MAX_ITER(99), .PAL_AW(5), .COLOR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_iter(in_iter),
        .mode(mode), .frame_start(frame_start), .cycle_en(cycle_en),
        .cycle_div(cycle_div), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .out_valid(out_valid), .o_RED(o_RED),
        .o_GREEN(o_GREEN), .o_BLUE(o_BLUE), .rot_offset(rot_offset)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [0:31][23:0] m_pal = palette_pkg::DEFAULT_PAL;
    int          m_rot = 0;
    int          m_fcnt = 0;
    logic        e_v1 = 1'b0, e_v2 = 1'b0;
    logic [23:0] e_c1 = '0, e_c2 = '0;

    function automatic logic [23:0] model_rgb(input logic [1:0] m, input int it, input int rot);
        logic [7:0] g;
        if (it >= 99) return 24'h000000;
        case (m)
            2'd0:    return 24'hFFFFFF;
            2'd1:    return m_pal[5'((it > 31) ? 31 : it)];
            2'd2:    return m_pal[5'((it + rot) % 32)];
            default: begin
                g = 8'(it * 2);
                return {g, g, g};
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_v1   <= 1'b0;
            e_v2   <= 1'b0;
            e_c1   <= '0;
            e_c2   <= '0;
            m_rot  <= 0;
            m_fcnt <= 0;
        end else begin
            e_v2 <= e_v1;
            e_c2 <= e_c1;
            e_v1 <= in_valid;
            e_c1 <= in_valid ? model_rgb(mode, int'(in_iter), m_rot) : 24'h000000;
            if (pal_we) m_pal[pal_waddr] <= pal_wdata;
            if (frame_start && cycle_en) begin
                if (m_fcnt == int'(cycle_div)) begin
                    m_fcnt <= 0;
                    m_rot  <= (m_rot + 1) % 32;
                end else begin
                    m_fcnt <= m_fcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_valid", 32'(out_valid), 32'(e_v2));
            chk("model_rgb", 32'({o_RED, o_GREEN, o_BLUE}), 32'(e_c2));
            chk("model_rot", 32'(rot_offset), 32'(m_rot));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] m, input logic [6:0] it);
        @(negedge clk);
        in_valid    = v;
        mode        = m;
        in_iter     = it;
        frame_start = 1'b0;
        pal_we      = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 7'd0);
    endtask

    function automatic logic [31:0] rgb();
        return 32'({o_RED, o_GREEN, o_BLUE});
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_rgb", rgb(), 32'h0);
        chk("reset_rot", 32'(rot_offset), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle();

        // B&W
        drive(1'b1, 2'd0, 7'd98);
        drive(1'b1, 2'd0, 7'd99);
        idle();
        chk("bw98_valid", 32'(out_valid), 32'd1);
        chk("bw98_rgb", rgb(), 32'hFFFFFF);
        idle();
        chk("bw99_valid", 32'(out_valid), 32'd1);
        chk("bw99_rgb", rgb(), 32'h000000);

        // Clamp
        drive(1'b1, 2'd1, 7'd40);
        drive(1'b1, 2'd1, 7'd12);
        drive(1'b1, 2'd1, 7'd98);
        chk("clamp40", rgb(), 32'h522205);
        drive(1'b1, 2'd1, 7'd99);
        chk("clamp12", rgb(), 32'h1852B1);
        idle();
        chk("clamp98", rgb(), 32'h522205);
        idle();
        chk("clamp99", rgb(), 32'h000000);

        // Rotation, cycle_div=1: four frames give two steps
        cycle_en  = 1'b1;
        cycle_div = 4'd1;
        for (int i = 0; i < 4; i++) begin
            idle();
            frame_start = 1'b1;
            idle();
        end
        idle();
        chk("rot_after4", 32'(rot_offset), 32'd2);

        // Wrap
        drive(1'b1, 2'd2, 7'd30);
        drive(1'b1, 2'd2, 7'd1);
        idle();
        chk("wrap30", rgb(), 32'h000000);
        idle();
        chk("wrap1", rgb(), 32'h04001F);

        // cycle_en=0 holds the offset
        cycle_en = 1'b0;
        idle();
        frame_start = 1'b1;
        idle();
        idle();
        chk("rot_hold", 32'(rot_offset), 32'd2);

        // cycle_div=0: one step per frame
        cycle_en  = 1'b1;
        cycle_div = 4'd0;
        idle();
        frame_start = 1'b1;
        idle();
        cycle_en = 1'b0;
        idle();
        chk("rot_div0", 32'(rot_offset), 32'd3);
        drive(1'b1, 2'd2, 7'd31);
        idle();
        idle();
        chk("wrap31_rot3", rgb(), 32'h020014);

        // Write/read collision on entry 5
        drive(1'b1, 2'd1, 7'd5);
        pal_we    = 1'b1;
        pal_waddr = 5'd5;
        pal_wdata = 24'h123456;
        drive(1'b1, 2'd1, 7'd5);
        idle();
        chk("collide_old", rgb(), 32'h06023C);
        idle();
        chk("collide_new", rgb(), 32'h123456);

        // Grayscale
        drive(1'b1, 2'd3, 7'h41);
        drive(1'b1, 2'd3, 7'd99);
        idle();
        chk("gray41", rgb(), 32'h828282);
        idle();
        chk("gray99", rgb(), 32'h000000);

        // Reset with two pixels in flight
        drive(1'b1, 2'd1, 7'd5);
        drive(1'b1, 2'd1, 7'd12);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", rgb(), 32'h0);
        chk("rst_rot", 32'(rot_offset), 32'd0);
        idle();
        idle();
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 7'd5);
        idle();
        idle();
        chk("keep_entry5", rgb(), 32'h123456);
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
